// File: rtl/crypto_iter_pkg.sv
// Shared types and the round function for the iterative cipher engine.
// Struct fields are sized for the widest supported build; modules zero-extend into them and slice out.
package crypto_iter_pkg;

  localparam int CI_ROT    = 5;
  localparam int CI_MAX_BW = 256;
  localparam int CI_MAX_RW = 8;
  localparam int CI_MAX_TW = 8;

  typedef enum logic {
    L_IDLE = 1'b0,
    L_BUSY = 1'b1
  } lane_state_e;

  typedef struct packed {
    logic [CI_MAX_BW-1:0] data;
    logic [CI_MAX_BW-1:0] key;
    logic [CI_MAX_RW-1:0] rounds;
    logic [CI_MAX_TW-1:0] tag;
  } lane_load_t;

  typedef struct packed {
    logic [CI_MAX_BW-1:0] data;
    logic                 valid;
  } rob_entry_t;

  // f(s, k, r) = rotl(s ^ k, CI_ROT) + r, confined to the low w bits (w >= 8).
  function automatic logic [CI_MAX_BW-1:0] ci_round(input logic [CI_MAX_BW-1:0] s,
                                                    input logic [CI_MAX_BW-1:0] k,
                                                    input logic [CI_MAX_RW-1:0] r,
                                                    input int unsigned w);
    logic [CI_MAX_BW-1:0] mask;
    logic [CI_MAX_BW-1:0] x;
    logic [CI_MAX_BW-1:0] rot;
    mask = {CI_MAX_BW{1'b1}} >> (CI_MAX_BW - w);
    x    = (s ^ k) & mask;
    rot  = ((x << CI_ROT) | (x >> (w - CI_ROT))) & mask;
    return (rot + {{(CI_MAX_BW-CI_MAX_RW){1'b0}}, r}) & mask;
  endfunction

endpackage

// File: rtl/crypto_iter_lane.sv
// One iterative cipher lane: loads a block, applies one round per cycle,
// and reports the final state with its reorder tag on the completing cycle.
//
// state  | meaning
// L_IDLE | lane free, may be loaded this cycle
// L_BUSY | applying round rnd_q; done asserted when rnd_q == rounds_q
module crypto_iter_lane
  import crypto_iter_pkg::*;
#(
  parameter int BW = 32,
  parameter int RW = 4,
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  lane_load_t    load,
  output logic          busy,
  output logic          done,
  output logic [TW-1:0] done_tag,
  output logic [BW-1:0] done_data
);

  lane_state_e state_q, state_d;

  logic [BW-1:0]        st_q;
  logic [BW-1:0]        key_q;
  logic [RW-1:0]        rounds_q;
  logic [RW-1:0]        rnd_q;
  logic [TW-1:0]        tag_q;
  logic [CI_MAX_BW-1:0] f_full;
  logic                 last;
  logic                 unused_bits;

  assign f_full = ci_round(CI_MAX_BW'(st_q), CI_MAX_BW'(key_q), CI_MAX_RW'(rnd_q), BW);
  assign last   = (state_q == L_BUSY) && (rnd_q == rounds_q);

  // Upper bits of the wide package structs are always zero in this build.
  assign unused_bits = ^{f_full >> BW, load.data >> BW, load.key >> BW,
                         load.rounds >> RW, load.tag >> TW};

  always_ff @(posedge clk) begin
    if (rst) state_q <= L_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      L_IDLE:  if (load_en) state_d = L_BUSY;
      L_BUSY:  if (last)    state_d = L_IDLE;
      default: state_d = L_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= '0;
      key_q    <= '0;
      rounds_q <= '0;
      rnd_q    <= '0;
      tag_q    <= '0;
    end else if (load_en) begin
      st_q     <= load.data[BW-1:0];
      key_q    <= load.key[BW-1:0];
      rounds_q <= load.rounds[RW-1:0];
      rnd_q    <= RW'(1);
      tag_q    <= load.tag[TW-1:0];
    end else if (state_q == L_BUSY) begin
      st_q  <= f_full[BW-1:0];
      rnd_q <= rnd_q + RW'(1);
    end
  end

  assign busy      = (state_q == L_BUSY);
  assign done      = last;
  assign done_tag  = tag_q;
  assign done_data = f_full[BW-1:0];

endmodule

// File: rtl/crypto_iter_engine.sv
// Multi-lane iterative cipher engine with a reorder buffer restoring arrival order.
// Define CRYPTO_ITER_PERF_EN to build the performance counters; otherwise they read 0.
module crypto_iter_engine
  import crypto_iter_pkg::*;
#(
  parameter  int BLOCK_WIDTH   = 32,
  parameter  int NUM_LANES     = 4,
  parameter  int ROB_DEPTH     = 8,
  parameter  int MAX_ROUNDS    = 15,
  parameter  int COUNTER_WIDTH = 32,
  localparam int ROUND_W       = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BLOCK_WIDTH-1:0]   cfg_key,
  input  logic [BLOCK_WIDTH-1:0]   data_in,
  input  logic [ROUND_W-1:0]       data_in_rounds,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [BLOCK_WIDTH-1:0]   data_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready,
  output logic [NUM_LANES-1:0]     lanes_busy,
  output logic [COUNTER_WIDTH-1:0] blocks_processed,
  output logic [COUNTER_WIDTH-1:0] cycles_elapsed,
  output logic [COUNTER_WIDTH-1:0] stall_cycles
);

  localparam int TAG_W  = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int OUT_W  = $clog2(ROB_DEPTH + 1);
  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0]   busy;
  logic [NUM_LANES-1:0]   done;
  logic [NUM_LANES-1:0]   load_en;
  logic [TAG_W-1:0]       done_tag  [NUM_LANES];
  logic [BLOCK_WIDTH-1:0] done_data [NUM_LANES];
  lane_load_t             load;

  logic                   run_q;
  logic [TAG_W-1:0]       wr_seq_q, rd_seq_q;
  logic [OUT_W-1:0]       outstanding_q;
  rob_entry_t             rob_q [ROB_DEPTH];
  rob_entry_t             head;
  logic                   unused_head;

  logic                   free_found;
  logic [LANE_W-1:0]      free_idx;
  logic                   accept, pop;
  logic [ROUND_W-1:0]     rounds_eff;

  function automatic logic [TAG_W-1:0] seq_inc(input logic [TAG_W-1:0] s);
    return (s == TAG_W'(ROB_DEPTH - 1)) ? '0 : s + TAG_W'(1);
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = LANE_W'(i);
      end
    end
  end

  // run_q keeps ready low through the first cycle after reset.
  assign data_in_ready = run_q && free_found && (outstanding_q < OUT_W'(ROB_DEPTH));
  assign accept        = data_in_valid && data_in_ready;
  assign pop           = data_out_valid && data_out_ready;

  always_comb begin
    rounds_eff = data_in_rounds;
    if (data_in_rounds == '0)                 rounds_eff = ROUND_W'(1);
    else if (int'(data_in_rounds) > MAX_ROUNDS) rounds_eff = ROUND_W'(MAX_ROUNDS);
  end

  always_comb begin
    load        = '0;
    load.data   = CI_MAX_BW'(data_in);
    load.key    = CI_MAX_BW'(cfg_key);
    load.rounds = CI_MAX_RW'(rounds_eff);
    load.tag    = CI_MAX_TW'(wr_seq_q);
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign load_en[g] = accept && (free_idx == LANE_W'(g));

    crypto_iter_lane #(
      .BW(BLOCK_WIDTH),
      .RW(ROUND_W),
      .TW(TAG_W)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en[g]),
      .load      (load),
      .busy      (busy[g]),
      .done      (done[g]),
      .done_tag  (done_tag[g]),
      .done_data (done_data[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob_q[i] <= '0;
    end else begin
      if (pop) rob_q[rd_seq_q].valid <= 1'b0;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (done[i]) begin
          rob_q[done_tag[i]].data  <= CI_MAX_BW'(done_data[i]);
          rob_q[done_tag[i]].valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q         <= 1'b0;
      wr_seq_q      <= '0;
      rd_seq_q      <= '0;
      outstanding_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) wr_seq_q <= seq_inc(wr_seq_q);
      if (pop)    rd_seq_q <= seq_inc(rd_seq_q);
      case ({accept, pop})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  assign head           = rob_q[rd_seq_q];
  assign data_out       = head.data[BLOCK_WIDTH-1:0];
  assign data_out_valid = head.valid;
  assign unused_head    = ^(head.data >> BLOCK_WIDTH);
  assign lanes_busy     = busy;

`ifdef CRYPTO_ITER_PERF_EN
  logic [COUNTER_WIDTH-1:0] blk_q, cyc_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q   <= '0;
      cyc_q   <= '0;
      stall_q <= '0;
    end else begin
      cyc_q <= cyc_q + COUNTER_WIDTH'(1);
      if (pop)                            blk_q   <= blk_q + COUNTER_WIDTH'(1);
      if (data_in_valid && !data_in_ready) stall_q <= stall_q + COUNTER_WIDTH'(1);
    end
  end

  assign blocks_processed = blk_q;
  assign cycles_elapsed   = cyc_q;
  assign stall_cycles     = stall_q;
`else
  assign blocks_processed = '0;
  assign cycles_elapsed   = '0;
  assign stall_cycles     = '0;
`endif

endmodule
